seq_alu_core: RTL and testbench

- Registered, parametrised ALU with a start/done handshake. Covers 8 logic and 8 arithmetic ops on WIDTH-bit operands.
- Single-cycle ops complete in 1 clock. Multiply is a multi-cycle shift-add unit that yields a 2*WIDTH-bit product.
- Sits between the operand/opcode source (switch or register bank) and the decoder/7-segment display path. Also returns status flags.

---
 rtl/seq_alu_core_pkg.sv | 40 ++++
 rtl/seq_alu_core_adder.sv | 36 +++
 rtl/seq_alu_core.sv | 179 +++++++++++++++++
 tb/tb_seq_alu_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_core_pkg.sv
// Shared constants for the sequential ALU: opcodes, modes, FSM states and
// the signed-overflow rule used by every add/subtract flavour.
package seq_alu_core_pkg;

  // Logic-mode opcodes (m = M_LOGIC)
  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_NAND  = 3'd2;
  localparam logic [2:0] OP_NOR   = 3'd3;
  localparam logic [2:0] OP_XOR   = 3'd4;
  localparam logic [2:0] OP_XNOR  = 3'd5;
  localparam logic [2:0] OP_NOTA  = 3'd6;
  localparam logic [2:0] OP_NOTB  = 3'd7;

  // Arithmetic-mode opcodes (m = M_ARITH)
  localparam logic [2:0] OP_PASSA = 3'd0;
  localparam logic [2:0] OP_PASSB = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_MUL   = 3'd4;
  localparam logic [2:0] OP_RSUB  = 3'd5;
  localparam logic [2:0] OP_INC   = 3'd6;
  localparam logic [2:0] OP_DEC   = 3'd7;

  localparam logic M_LOGIC = 1'b0;
  localparam logic M_ARITH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Two's-complement overflow: operands agree in sign, result does not.
  function automatic logic signed_ovf(input logic x_msb, input logic y_msb,
                                      input logic sum_msb);
    return (x_msb == y_msb) && (sum_msb != x_msb);
  endfunction

endpackage

// File: rtl/seq_alu_core_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
module alu_full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = x ^ y ^ ci;
  assign co  = (x & y) | (ci & (x ^ y));
endmodule

module alu_ripple_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             ci,
  output logic [WIDTH-1:0] sum,
  output logic             co
);
  logic [WIDTH:0] carry;

  assign carry[0] = ci;
  assign co       = carry[WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    alu_full_adder u_fa (
      .x   (x[i]),
      .y   (y[i]),
      .ci  (carry[i]),
      .sum (sum[i]),
      .co  (carry[i+1])
    );
  end
endmodule

// File: rtl/seq_alu_core.sv
// Registered ALU with start/done handshake. Logic and add-type ops finish in
// one clock; multiply runs a WIDTH-iteration shift-add loop on the shared adder.
module seq_alu_core
  import seq_alu_core_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [2:0]       op,
  input  logic             m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] s_hi,
  output logic             c_out,
  output logic             zero,
  output logic             ovf
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_ci;
  logic [WIDTH-1:0] add_sum;
  logic             add_co;

  logic [WIDTH-1:0] res_s;
  logic             res_c;
  logic             res_v;

  logic [WIDTH-1:0] acc_hi_nx;
  logic [WIDTH-1:0] acc_lo_nx;
  logic             is_mul;
  logic             last_iter;

  assign is_mul    = (m == M_ARITH) && (op == OP_MUL);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // Accumulate step: {carry, sum, acc_lo} shifted right by one.
  assign acc_hi_nx = {add_co, add_sum[WIDTH-1:1]};
  assign acc_lo_nx = {add_sum[0], acc_lo[WIDTH-1:1]};

  // Select adder operands: multiply accumulate while in MUL, else the live op.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    add_x  = a;
    add_y  = '0;
    add_ci = 1'b0;
    if (state == ST_MUL) begin
      add_x = acc_hi;
      add_y = mplier[0] ? mcand : '0;
    end else if (m == M_ARITH) begin
      case (op)
        OP_ADD:  begin add_y = b;  add_ci = c_in; end
        OP_SUB:  begin add_y = ~b; add_ci = 1'b1; end
        OP_RSUB: begin add_x = b;  add_y = ~a; add_ci = 1'b1; end
        OP_INC:  add_ci = 1'b1;
        OP_DEC:  add_y = '1;
        default: ;
      endcase
    end
  end

  alu_ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .x   (add_x),
    .y   (add_y),
    .ci  (add_ci),
    .sum (add_sum),
    .co  (add_co)
  );

  // Single-cycle result and flags for the op presented on the inputs.
  always_comb begin
    res_s = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    if (m == M_LOGIC) begin
      case (op)
        OP_AND:  res_s = a & b;
        OP_OR:   res_s = a | b;
        OP_NAND: res_s = ~(a & b);
        OP_NOR:  res_s = ~(a | b);
        OP_XOR:  res_s = a ^ b;
        OP_XNOR: res_s = ~(a ^ b);
        OP_NOTA: res_s = ~a;
        default: res_s = ~b;
      endcase
    end else begin
      case (op)
        OP_PASSA: res_s = a;
        OP_PASSB: res_s = b;
        OP_MUL:   res_s = '0;
        default: begin
          res_s = add_sum;
          res_c = add_co;
          res_v = signed_ovf(add_x[WIDTH-1], add_y[WIDTH-1], add_sum[WIDTH-1]);
        end
      endcase
    end
  end

  // Control FSM with registered outputs; FIN behaves like IDLE for new starts
  // so an op can be launched in the same cycle done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      s      <= '0;
      s_hi   <= '0;
      c_out  <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_FIN: begin
          state <= ST_IDLE;
          if (start) begin
            if (is_mul) begin
              acc_hi <= '0;
              acc_lo <= '0;
              mcand  <= a;
              mplier <= b;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= ST_MUL;
            end else begin
              s     <= res_s;
              s_hi  <= '0;
              c_out <= res_c;
              ovf   <= res_v;
              zero  <= (res_s == '0);
              done  <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc_hi <= acc_hi_nx;
          acc_lo <= acc_lo_nx;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last_iter) begin
            s     <= acc_lo_nx;
            s_hi  <= acc_hi_nx;
            c_out <= |acc_hi_nx;
            ovf   <= 1'b0;
            zero  <= ({acc_hi_nx, acc_lo_nx} == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_FIN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_core.sv
// Self-checking bench for seq_alu_core (WIDTH=4): directed vector table,
// randomized ops against an arithmetic reference model, and handshake corners.
module tb_seq_alu_core;
  import seq_alu_core_pkg::*;

  localparam int W       = 4;
  localparam int MUL_LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic [2:0]   op = '0;
  logic         m = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic [W-1:0] s_hi;
  logic         c_out;
  logic         zero;
  logic         ovf;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [W-1:0] s;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         v;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [2:0]   op;
    logic         m;
    logic [W-1:0] s;
    logic [W-1:0] hi;
    logic         c;
    logic         z;
    logic         v;
    int           lat;
  } vec_t;

  always #5 clk = ~clk;

  seq_alu_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .op    (op),
    .m     (m),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .s_hi  (s_hi),
    .c_out (c_out),
    .zero  (zero),
    .ovf   (ovf)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic res_t model(input int ia, input int ib, input int icin,
                                 input int iop, input logic im);
    res_t r;
    int sa, sb, t, st;
    logic signed_op;
    r = '{default: '0};
    sa = (ia >= 8) ? ia - 16 : ia;
    sb = (ib >= 8) ? ib - 16 : ib;
    t = 0;
    st = 0;
    signed_op = 1'b0;
    if (im == M_LOGIC) begin
      case (iop)
        0: t = ia & ib;
        1: t = ia | ib;
        2: t = ~(ia & ib);
        3: t = ~(ia | ib);
        4: t = ia ^ ib;
        5: t = ~(ia ^ ib);
        6: t = ~ia;
        default: t = ~ib;
      endcase
    end else begin
      case (iop)
        0: t = ia;
        1: t = ib;
        2: begin t = ia + ib + icin; r.c = (t > 15);     st = sa + sb + icin; signed_op = 1'b1; end
        3: begin t = ia - ib;        r.c = (ia >= ib);   st = sa - sb;        signed_op = 1'b1; end
        4: begin t = ia * ib;        r.hi = 4'(t >> 4);  r.c = (t >= 16); end
        5: begin t = ib - ia;        r.c = (ib >= ia);   st = sb - sa;        signed_op = 1'b1; end
        6: begin t = ia + 1;         r.c = (ia == 15);   st = sa + 1;         signed_op = 1'b1; end
        default: begin t = ia - 1;   r.c = (ia != 0);    st = sa - 1;         signed_op = 1'b1; end
      endcase
    end
    r.s = 4'(t);
    r.v = signed_op && (st < -8 || st > 7);
    r.z = (r.s == 0) && (r.hi == 0);
    return r;
  endfunction

  // Present an op with a one-cycle start pulse; returns #1 after the accept edge.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                        input logic [2:0] top, input logic tm);
    @(negedge clk);
    a = ta; b = tb; c_in = tcin; op = top; m = tm; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Bounded wait for done; lat counts accept edge as 1.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input res_t e, input int exp_lat, input int lat);
    check({tag, ".lat"},  lat,   exp_lat);
    check({tag, ".s"},    s,     e.s);
    check({tag, ".s_hi"}, s_hi,  e.hi);
    check({tag, ".c"},    c_out, e.c);
    check({tag, ".zero"}, zero,  e.z);
    check({tag, ".ovf"},  ovf,   e.v);
    check({tag, ".busy"}, busy,  1'b0);
  endtask

  initial begin
    vec_t vecs[15];
    res_t e;
    int   lat;
    int   n_done;

    vecs[0]  = '{4'hA, 4'h6, 1'b0, OP_XOR,   M_LOGIC, 4'hC, 4'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{4'h5, 4'h5, 1'b0, OP_XOR,   M_LOGIC, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{4'h7, 4'h1, 1'b0, OP_ADD,   M_ARITH, 4'h8, 4'h0, 1'b0, 1'b0, 1'b1, 1};
    vecs[3]  = '{4'hF, 4'h1, 1'b0, OP_ADD,   M_ARITH, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1};
    vecs[4]  = '{4'h3, 4'h5, 1'b0, OP_SUB,   M_ARITH, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'h0, 4'h5, 1'b0, OP_DEC,   M_ARITH, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'hF, 4'hD, 1'b0, OP_MUL,   M_ARITH, 4'h3, 4'hC, 1'b1, 1'b0, 1'b0, MUL_LAT};
    vecs[7]  = '{4'hA, 4'h6, 1'b0, OP_NAND,  M_LOGIC, 4'hD, 4'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'h3, 4'h5, 1'b1, OP_RSUB,  M_ARITH, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 1};
    vecs[9]  = '{4'h7, 4'h0, 1'b0, OP_INC,   M_ARITH, 4'h8, 4'h0, 1'b0, 1'b0, 1'b1, 1};
    vecs[10] = '{4'h0, 4'h6, 1'b0, OP_NOTB,  M_LOGIC, 4'h9, 4'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[11] = '{4'h0, 4'h9, 1'b0, OP_MUL,   M_ARITH, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, MUL_LAT};
    vecs[12] = '{4'h2, 4'h4, 1'b1, OP_PASSB, M_ARITH, 4'h4, 4'h0, 1'b0, 1'b0, 1'b0, 1};
    vecs[13] = '{4'h8, 4'h8, 1'b1, OP_ADD,   M_ARITH, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 1};
    vecs[14] = '{4'h8, 4'h1, 1'b0, OP_SUB,   M_ARITH, 4'h7, 4'h0, 1'b1, 1'b0, 1'b1, 1};

    // Reset state
    #2 rst_n = 1'b0;
    #20;
    check("reset.outputs", {busy, done, s, s_hi, c_out, zero, ovf}, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, vecs[i].m);
      wait_done(lat);
      e = '{vecs[i].s, vecs[i].hi, vecs[i].c, vecs[i].z, vecs[i].v};
      check_result($sformatf("vec%0d", i), e, vecs[i].lat, lat);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.done_pulse", i), done, 1'b0);
    end

    // Randomized ops against the model
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] ra, rb;
      logic rc, rm;
      logic [2:0] rop;
      ra  = W'($urandom_range(0, 15));
      rb  = W'($urandom_range(0, 15));
      rc  = 1'($urandom_range(0, 1));
      rm  = 1'($urandom_range(0, 1));
      rop = 3'($urandom_range(0, 7));
      e = model(int'(ra), int'(rb), int'(rc), int'(rop), rm);
      launch(ra, rb, rc, rop, rm);
      wait_done(lat);
      check_result($sformatf("rnd%0d", i), e, (rm && rop == OP_MUL) ? MUL_LAT : 1, lat);
    end

    // Reset two cycles into a multiply: outputs clear at once, no done follows
    launch(4'hF, 4'hF, 1'b0, OP_MUL, M_ARITH);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mul.outputs", {busy, done, s, s_hi, c_out, zero, ovf}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("rst_mid_mul.no_done", n_done, 0);
    launch(4'h2, 4'h3, 1'b0, OP_ADD, M_ARITH);
    wait_done(lat);
    check_result("after_rst", model(2, 3, 0, OP_ADD, M_ARITH), 1, lat);

    // Multiply with ignored start and operand changes while busy
    launch(4'hF, 4'hD, 1'b0, OP_MUL, M_ARITH);
    lat = 1;
    check("mul_busy.c1", {busy, done}, 2'b10);
    @(negedge clk);
    a = 4'h1; b = 4'h2; op = OP_XOR; m = M_LOGIC; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    check("mul_busy.c2", {busy, done}, 2'b10);
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!done) check($sformatf("mul_busy.c%0d", lat), busy, 1'b1);
    end
    check_result("mul_ignore", model(15, 13, 0, OP_MUL, M_ARITH), MUL_LAT, lat);
    @(posedge clk); #1;
    check("mul_ignore.no_extra_done", done, 1'b0);

    // Back-to-back: ADD started in the cycle the multiply's done is high
    launch(4'h6, 4'h7, 1'b0, OP_MUL, M_ARITH);
    wait_done(lat);
    check_result("b2b_mul", model(6, 7, 0, OP_MUL, M_ARITH), MUL_LAT, lat);
    a = 4'h3; b = 4'h4; c_in = 1'b0; op = OP_ADD; m = M_ARITH; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_add.done", done, 1'b1);
    check("b2b_add.s", s, 4'h7);
    check("b2b_add.s_hi", s_hi, 4'h0);
    check("b2b_add.c", c_out, 1'b0);
    @(posedge clk); #1;
    check("b2b_add.done_pulse", done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
